minmax_tracker: RTL and testbench
=================================

# minmax_tracker

Streaming frame analyser for 4-bit samples. For one frame of N samples it tracks the running maximum and minimum. It also classifies each sample against its predecessor as greater, equal or less, and counts each class. Results are presented on a valid/ready output port. The block sits downstream of sample producers and is the sequential consumer of the team's three-way magnitude comparison.

## Interface
- WIDTH, 4, sample width in bits
- CNT_W, 8, width of frame length and of each class counter
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new frame; honoured only in IDLE
- frame_len  input  CNT_W  samples per frame; sampled when start is honoured
- in_valid  input  1  sample offered
- in_ready  output  1  block accepts sample; high exactly in RUN
- in_data  input  WIDTH  sample value, unsigned
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes result
- out_max  output  WIDTH  largest sample of frame
- out_min  output  WIDTH  smallest sample of frame
- out_gt  output  CNT_W  count of samples strictly greater than predecessor
- out_eq  output  CNT_W  count of samples equal to predecessor
- out_lt  output  CNT_W  count of samples strictly less than predecessor

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 and frame_len≠0: latch frame_len into remaining counter, clear max/min/prev/counters to 0, go to RUN.
  - start=1 and frame_len=0: ignored, stay in IDLE.
- RUN:
  - A sample is accepted when in_valid & in_ready.
  - First accepted sample loads max, min and prev with in_data. No class counter changes.
  - Each later sample is compared unsigned against prev. Exactly one of out_gt/out_eq/out_lt increments.
  - On each later sample, max is replaced if in_data > max and min is replaced if in_data < min. prev is loaded with in_data.
  - remaining decrements per accept. The accept that takes remaining from 1 to 0 moves the state to DONE.
- DONE: out_valid=1 and outputs held stable. The out_valid & out_ready handshake moves the state to IDLE.
- start is ignored outside IDLE. in_valid is ignored outside RUN.
- Counters cannot overflow because at most frame_len−1 ≤ 2^CNT_W−1 comparisons occur. Invariant in DONE: out_gt+out_eq+out_lt = frame_len−1.
- Results stay on out_* after handshake, until the next honoured start clears them.
- All comparisons are unsigned. 15 > 0 with no wrap semantics.

## Timing
- Reset: state IDLE; in_ready=0, out_valid=0, out_max=0, out_min=0, out_gt=out_eq=out_lt=0, remaining=0.
- rst mid-RUN or mid-DONE: the next cycle is IDLE with all outputs at reset values. The partial frame is discarded.
- start honoured at edge k → in_ready=1 from cycle k+1.
- Throughput: one sample per cycle in RUN.
- Last sample accepted at edge k → out_valid=1 and final results visible in cycle k+1. In that same cycle in_ready=0.
- out_ready may already be high when out_valid rises. In that case the handshake completes in the first DONE cycle, and IDLE follows the next cycle.
- out_ready held low → DONE persists indefinitely with outputs unchanged.
- start asserted during the handshake cycle is ignored. Minimum gap between frames is one IDLE cycle.
- in_ready and out_valid are decoded from registered state only, never combinationally from inputs.

## Structure
- Shared package minmax_pkg holds the state enum (IDLE, RUN, DONE) and the default WIDTH/CNT_W constants.
- One sub-module, cmp3_unit: combinational, WIDTH-parameterised unsigned compare with one-hot gt/eq/lt outputs.
  - Two instances: sample vs prev for classification, and sample vs max/min for extremum update. Alternatively, use one instance for classification plus inline relational compares for max/min.
- The top holds the FSM, the remaining counter and the result registers.

## Test plan
- frame_len=4, samples 3,7,7,2 back-to-back → out_valid the cycle after the 4th accept; max=7, min=2, gt=1, eq=1, lt=1.
- frame_len=1, sample 9 → max=9, min=9, gt=eq=lt=0; out_valid 1 cycle after the accept.
- frame_len=3, samples 15,0,15 with in_valid gaps of 2 cycles → max=15, min=0, gt=1, lt=1, eq=0; in_ready stays high through the gaps.
- Backpressure: after the result, hold out_ready=0 for 5 cycles → out_valid and all outputs constant. Assert start during DONE → no effect. Raise out_ready → IDLE next cycle.
- start with frame_len=0 → stays IDLE, in_ready=0. Then frame_len=2 with samples 5,5 → eq=1, max=min=5.
- rst=1 for one cycle after 2 of 4 samples → next cycle IDLE, all outputs 0. A fresh frame then yields correct results with no carry-over.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and default sizing for the min/max frame analyser.
package minmax_pkg;

    // Default sample width and counter/frame-length width.
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 8;

    // Frame-level control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cmp3_unit.sv
// Combinational unsigned three-way magnitude compare; exactly one output is high.
module cmp3_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // Decode a versus b into a one-hot greater/equal/less triple.
    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (a > b) begin
            gt = 1'b1;
        end else if (a == b) begin
            eq = 1'b1;
        end else begin
            lt = 1'b1;
        end
    end

endmodule

// File: rtl/minmax_tracker.sv
// Frame analyser: running max/min of a sample stream plus counts of samples
// greater than, equal to and less than their predecessor.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_gt,
    output logic [CNT_W-1:0] out_eq,
    output logic [CNT_W-1:0] out_lt
);

    state_e           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] prev_q;
    logic             first_q;
    logic [CNT_W-1:0] gt_q;
    logic [CNT_W-1:0] eq_q;
    logic [CNT_W-1:0] lt_q;

    logic cls_gt;
    logic cls_eq;
    logic cls_lt;
    logic accept;

    // Classify the incoming sample against its predecessor.
    cmp3_unit #(
        .WIDTH (WIDTH)
    ) u_cmp_prev (
        .a  (in_data),
        .b  (prev_q),
        .gt (cls_gt),
        .eq (cls_eq),
        .lt (cls_lt)
    );

    assign accept = in_valid && (state_q == RUN);

    // FSM, remaining counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            max_q       <= '0;
            min_q       <= '0;
            prev_q      <= '0;
            first_q     <= 1'b0;
            gt_q        <= '0;
            eq_q        <= '0;
            lt_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A zero-length frame request is dropped.
                    if (start && (frame_len != '0)) begin
                        remaining_q <= frame_len;
                        max_q       <= '0;
                        min_q       <= '0;
                        prev_q      <= '0;
                        first_q     <= 1'b1;
                        gt_q        <= '0;
                        eq_q        <= '0;
                        lt_q        <= '0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        prev_q      <= in_data;
                        if (first_q) begin
                            // First sample seeds the extremes; nothing to compare yet.
                            max_q   <= in_data;
                            min_q   <= in_data;
                            first_q <= 1'b0;
                        end else begin
                            if (cls_gt) gt_q <= gt_q + CNT_W'(1);
                            if (cls_eq) eq_q <= eq_q + CNT_W'(1);
                            if (cls_lt) lt_q <= lt_q + CNT_W'(1);
                            if (in_data > max_q) max_q <= in_data;
                            if (in_data < min_q) min_q <= in_data;
                        end
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results remain on the outputs after the handshake.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags come from registered state only.
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out_max   = max_q;
    assign out_min   = min_q;
    assign out_gt    = gt_q;
    assign out_eq    = eq_q;
    assign out_lt    = lt_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: directed frames push expected results,
// a monitor pops and compares whenever a result is presented.
module tb_minmax_tracker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mn;
        logic [CNT_W-1:0] gt;
        logic [CNT_W-1:0] eq;
        logic [CNT_W-1:0] lt;
    } result_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] frame_len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [CNT_W-1:0] out_gt;
    logic [CNT_W-1:0] out_eq;
    logic [CNT_W-1:0] out_lt;

    result_t exp_q[$];
    int      n_tests;
    int      n_fail;
    logic    seen;

    minmax_tracker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_gt    (out_gt),
        .out_eq    (out_eq),
        .out_lt    (out_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare against the scoreboard on the first cycle of each result.
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("max", int'(out_max), int'(e.mx));
                check("min", int'(out_min), int'(e.mn));
                check("gt",  int'(out_gt),  int'(e.gt));
                check("eq",  int'(out_eq),  int'(e.eq));
                check("lt",  int'(out_lt),  int'(e.lt));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Issue start for one cycle; expects to be called right after a negedge.
    task automatic start_frame(input int len);
        start     = 1'b1;
        frame_len = CNT_W'(len);
        @(negedge clk);
        start = 1'b0;
        check("in_ready_after_start", int'(in_ready), (len != 0) ? 1 : 0);
    endtask

    // Offer one sample after gap idle cycles; in_valid stays up until the caller drops it.
    task automatic send(input int d, input int gap);
        int waited;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("in_ready_in_gap", int'(in_ready), 1);
        end
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_wait", 0, 1);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        @(negedge clk);
    endtask

    task automatic push(input int mx, input int mn, input int gt, input int eq, input int lt);
        result_t r;
        r.mx = WIDTH'(mx);
        r.mn = WIDTH'(mn);
        r.gt = CNT_W'(gt);
        r.eq = CNT_W'(eq);
        r.lt = CNT_W'(lt);
        exp_q.push_back(r);
    endtask

    // Called right after the last sample: result must be up now, then drained.
    task automatic finish_frame(input int mx);
        in_valid = 1'b0;
        check("out_valid_latency", int'(out_valid), 1);
        check("in_ready_in_done", int'(in_ready), 0);
        @(negedge clk);
        check("idle_after_handshake", int'(out_valid), 0);
        check("result_retained", int'(out_max), mx);
    endtask

    task automatic check_zero(input string name);
        check({name, "_in_ready"}, int'(in_ready), 0);
        check({name, "_out_valid"}, int'(out_valid), 0);
        check({name, "_outs"}, int'({out_max, out_min, out_gt, out_eq, out_lt}), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] hold_max;
        n_tests   = 0;
        n_fail    = 0;
        seen      = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        // Back-to-back frame of four samples.
        push(7, 2, 1, 1, 1);
        start_frame(4);
        send(3, 0); send(7, 0); send(7, 0); send(2, 0);
        finish_frame(7);

        // Single-sample frame.
        push(9, 9, 0, 0, 0);
        start_frame(1);
        send(9, 0);
        finish_frame(9);

        // Extremes with idle gaps between samples.
        push(15, 0, 1, 0, 1);
        start_frame(3);
        send(15, 0); send(0, 2); send(15, 2);
        finish_frame(15);

        // Backpressure in DONE with a stray start.
        push(4, 1, 1, 0, 0);
        out_ready = 1'b0;
        start_frame(2);
        send(1, 0); send(4, 0);
        in_valid = 1'b0;
        hold_max = out_max;
        start     = 1'b1;
        frame_len = CNT_W'(3);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_max_stable", int'(out_max), int'(hold_max));
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after_ready", int'(out_valid), 0);
        check("bp_start_ignored", int'(in_ready), 0);

        // Zero-length request is dropped; then a two-sample equal frame.
        start_frame(0);
        @(negedge clk);
        check("len0_stays_idle", int'(in_ready), 0);
        push(5, 5, 0, 1, 0);
        start_frame(2);
        send(5, 0); send(5, 0);
        finish_frame(5);

        // Reset mid-frame discards everything.
        start_frame(4);
        send(8, 0); send(1, 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_rst");
        push(6, 2, 0, 1, 1);
        start_frame(3);
        send(6, 0); send(6, 0); send(2, 0);
        finish_frame(6);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
